// File: rtl/fetch_pred_queue_pkg.sv
// Shared fetch-batch types: BTB per-slot prediction and the buffered batch entry.
package fetch_pred_queue_pkg;
  localparam int NR_FETCH_SLOTS    = 4;
  localparam int FETCH_BATCH_BYTES = 16;

  typedef struct packed {
    logic        valid;
    logic [63:0] predict_address;
    logic        predict_taken;
  } branchpredict_sbe_t;

  typedef struct packed {
    logic [63:0]                          vaddr;
    logic [NR_FETCH_SLOTS-1:0][31:0]      instr;
    branchpredict_sbe_t [NR_FETCH_SLOTS-1:0] pred;
    logic [NR_FETCH_SLOTS-1:0]            slot_mask;
    logic                                 taken;
    logic [63:0]                          next_pc;
  } fetch_batch_t;
endpackage

// File: rtl/fetch_pred_queue_if.sv
// Producer (BTB/I-cache) and consumer (decode) handshakes of the fetch prediction queue.
interface fetch_pred_queue_if #(parameter int DEPTH = 4);
  import fetch_pred_queue_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic                      flush_i;
  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [63:0]               in_vaddr_i;
  logic [127:0]              in_instr_i;
  branchpredict_sbe_t [3:0]  in_pred_i;
  logic                      in_any_taken_i;
  logic [1:0]                in_taken_slot_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [63:0]               out_vaddr_o;
  logic [127:0]              out_instr_o;
  branchpredict_sbe_t [3:0]  out_pred_o;
  logic [3:0]                out_slot_mask_o;
  logic                      out_taken_o;
  logic [63:0]               out_next_pc_o;
  logic [CW-1:0]             count_o;

  modport slave (
    input  flush_i, in_valid_i, in_vaddr_i, in_instr_i, in_pred_i, in_any_taken_i,
           in_taken_slot_i, out_ready_i,
    output in_ready_o, out_valid_o, out_vaddr_o, out_instr_o, out_pred_o,
           out_slot_mask_o, out_taken_o, out_next_pc_o, count_o
  );
  modport master (
    output flush_i, in_valid_i, in_vaddr_i, in_instr_i, in_pred_i, in_any_taken_i,
           in_taken_slot_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_vaddr_o, out_instr_o, out_pred_o,
           out_slot_mask_o, out_taken_o, out_next_pc_o, count_o
  );
endinterface

// File: rtl/fetch_slot_mask_gen.sv
// Live-slot mask, taken flag and predicted next PC for one fetch batch (combinational).
module fetch_slot_mask_gen
  import fetch_pred_queue_pkg::*;
#(
  parameter int NR_SLOTS = 4
) (
  input  logic [63:0]                        vaddr_i,
  input  branchpredict_sbe_t [NR_SLOTS-1:0]  pred_i,
  input  logic                               any_taken_i,
  input  logic [$clog2(NR_SLOTS)-1:0]        taken_slot_i,
  output logic [NR_SLOTS-1:0]                slot_mask_o,
  output logic                               taken_o,
  output logic [63:0]                        next_pc_o
);
  localparam int SW    = $clog2(NR_SLOTS);
  localparam int OFS_W = $clog2(FETCH_BATCH_BYTES);

  logic [SW-1:0] start_slot, end_slot;

  always_comb begin
    start_slot = vaddr_i[OFS_W-1:2];
    // A taken slot before the start slot, or one the BTB did not mark valid+taken,
    // is an inconsistent prediction and falls back to sequential fetch.
    taken_o    = any_taken_i && (taken_slot_i >= start_slot) &&
                 pred_i[taken_slot_i].valid && pred_i[taken_slot_i].predict_taken;
    end_slot   = taken_o ? taken_slot_i : SW'(NR_SLOTS - 1);
    slot_mask_o = '0;
    for (int s = 0; s < NR_SLOTS; s++)
      slot_mask_o[s] = (SW'(s) >= start_slot) && (SW'(s) <= end_slot);
    next_pc_o  = taken_o ? pred_i[end_slot].predict_address
                         : {vaddr_i[63:OFS_W] + (64-OFS_W)'(1), OFS_W'(0)};
  end
endmodule

// File: rtl/fetch_pred_queue.sv
// FIFO of annotated fetch batches between the BTB and decode; registered ready, no fall-through.
module fetch_pred_queue
  import fetch_pred_queue_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int NR_SLOTS = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  fetch_pred_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic           in_ready_q, in_ready_d;
  logic           empty, push, pop;
  fetch_batch_t   mem_q [DEPTH];
  fetch_batch_t   entry_d, head;
  logic [3:0]     mask;
  logic           taken;
  logic [63:0]    next_pc;

  fetch_slot_mask_gen #(.NR_SLOTS(NR_SLOTS)) u_mask (
    .vaddr_i      (bus.in_vaddr_i),
    .pred_i       (bus.in_pred_i),
    .any_taken_i  (bus.in_any_taken_i),
    .taken_slot_i (bus.in_taken_slot_i),
    .slot_mask_o  (mask),
    .taken_o      (taken),
    .next_pc_o    (next_pc)
  );

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = bus.in_valid_i && in_ready_q;
  assign pop   = !empty && bus.out_ready_i;

  always_comb begin
    entry_d.vaddr     = bus.in_vaddr_i;
    entry_d.instr     = bus.in_instr_i;
    entry_d.pred      = bus.in_pred_i;
    entry_d.slot_mask = mask;
    entry_d.taken     = taken;
    entry_d.next_pc   = next_pc;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // Ready is precomputed from next-cycle occupancy so it never depends on out_ready_i.
    in_ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      in_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= in_ready_d;
      if (push && !bus.flush_i) mem_q[wr_ptr_q[AW-1:0]] <= entry_d;
    end
  end

  always_comb begin
    head = '0;
    if (!empty) head = mem_q[rd_ptr_q[AW-1:0]];
  end

  assign bus.in_ready_o      = in_ready_q;
  assign bus.out_valid_o     = !empty;
  assign bus.out_vaddr_o     = head.vaddr;
  assign bus.out_instr_o     = head.instr;
  assign bus.out_pred_o      = head.pred;
  assign bus.out_slot_mask_o = head.slot_mask;
  assign bus.out_taken_o     = head.taken;
  assign bus.out_next_pc_o   = head.next_pc;
  assign bus.count_o         = wr_ptr_q - rd_ptr_q;
endmodule

// File: tb/tb_fetch_pred_queue.sv
// Directed and randomized checks of fetch_pred_queue against a queue-based reference model.
module tb_fetch_pred_queue;
  import fetch_pred_queue_pkg::*;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_pred_queue_if #(.DEPTH(DEPTH)) bus();

  fetch_pred_queue #(.DEPTH(DEPTH), .NR_SLOTS(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  fetch_batch_t mq[$];

  function automatic fetch_batch_t model_entry(logic [63:0] va, logic [127:0] ins,
      branchpredict_sbe_t [3:0] pr, logic any, logic [1:0] sl);
    fetch_batch_t e;
    int st = int'(va[3:2]);
    int ts = int'(sl);
    bit tk = any && (ts >= st) && pr[ts].valid && pr[ts].predict_taken;
    int en = tk ? ts : 3;
    e.vaddr = va;
    e.instr = ins;
    e.pred  = pr;
    for (int s = 0; s < 4; s++) e.slot_mask[s] = (s >= st) && (s <= en);
    e.taken   = tk;
    e.next_pc = tk ? pr[en].predict_address : (va & ~64'hF) + 64'd16;
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    fetch_batch_t h = '0;
    if (mq.size() > 0) h = mq[0];
    chk("count", 64'(bus.count_o), 64'(mq.size()));
    chk("in_ready", 64'(bus.in_ready_o), 64'(mq.size() < DEPTH));
    chk("out_valid", 64'(bus.out_valid_o), 64'(mq.size() > 0));
    chk("vaddr", bus.out_vaddr_o, h.vaddr);
    for (int s = 0; s < 4; s++) begin
      chk("instr", 64'(bus.out_instr_o[32*s +: 32]), 64'(h.instr[s]));
      chk("pred_addr", bus.out_pred_o[s].predict_address, h.pred[s].predict_address);
      chk("pred_flags", 64'({bus.out_pred_o[s].valid, bus.out_pred_o[s].predict_taken}),
          64'({h.pred[s].valid, h.pred[s].predict_taken}));
    end
    chk("mask", 64'(bus.out_slot_mask_o), 64'(h.slot_mask));
    chk("taken", 64'(bus.out_taken_o), 64'(h.taken));
    chk("next_pc", bus.out_next_pc_o, h.next_pc);
  endtask

  // One clock: predict from pre-edge inputs, then compare #1 after the edge.
  task automatic tick();
    bit do_push = bus.in_valid_i && (mq.size() < DEPTH);
    bit do_pop  = bus.out_ready_i && (mq.size() > 0);
    bit clr     = rst || bus.flush_i;
    fetch_batch_t e = model_entry(bus.in_vaddr_i, bus.in_instr_i, bus.in_pred_i,
                                  bus.in_any_taken_i, bus.in_taken_slot_i);
    @(posedge clk);
    #1;
    if (clr) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    check_all();
  endtask

  task automatic rand_batch();
    logic [63:0] va = {$urandom, $urandom};
    if ($urandom_range(0, 7) == 0) va[63:4] = '1;
    bus.in_vaddr_i  = va;
    bus.in_instr_i  = {$urandom, $urandom, $urandom, $urandom};
    for (int s = 0; s < 4; s++) begin
      bus.in_pred_i[s].valid           = 1'($urandom_range(0, 3) != 0);
      bus.in_pred_i[s].predict_taken   = 1'($urandom_range(0, 1));
      bus.in_pred_i[s].predict_address = {$urandom, $urandom};
    end
    bus.in_any_taken_i  = 1'($urandom_range(0, 1));
    bus.in_taken_slot_i = 2'($urandom_range(0, 3));
  endtask

  task automatic drain();
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    bus.out_ready_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.flush_i = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.in_vaddr_i = '0;
    bus.in_instr_i = '0;
    bus.in_pred_i = '0;
    bus.in_any_taken_i = 1'b0;
    bus.in_taken_slot_i = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", 64'(bus.count_o), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_mask", 64'(bus.out_slot_mask_o), 64'd0);
    chk("rst_taken", 64'(bus.out_taken_o), 64'd0);

    // Sequential batch starting mid-line
    rand_batch();
    bus.in_vaddr_i = 64'h1004;
    bus.in_any_taken_i = 1'b0;
    bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    chk("t1_valid", 64'(bus.out_valid_o), 64'd1);
    chk("t1_mask", 64'(bus.out_slot_mask_o), 64'b1110);
    chk("t1_taken", 64'(bus.out_taken_o), 64'd0);
    chk("t1_next_pc", bus.out_next_pc_o, 64'h1010);
    drain();

    // Predicted-taken branch in slot 2
    rand_batch();
    bus.in_vaddr_i = 64'h2000;
    bus.in_any_taken_i = 1'b1;
    bus.in_taken_slot_i = 2'd2;
    bus.in_pred_i[2].valid = 1'b1;
    bus.in_pred_i[2].predict_taken = 1'b1;
    bus.in_pred_i[2].predict_address = 64'h3000;
    bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    chk("t2_mask", 64'(bus.out_slot_mask_o), 64'b0111);
    chk("t2_taken", 64'(bus.out_taken_o), 64'd1);
    chk("t2_next_pc", bus.out_next_pc_o, 64'h3000);
    drain();

    // Taken slot before the start slot is ignored
    rand_batch();
    bus.in_vaddr_i = 64'h200C;
    bus.in_any_taken_i = 1'b1;
    bus.in_taken_slot_i = 2'd1;
    bus.in_pred_i[1].valid = 1'b1;
    bus.in_pred_i[1].predict_taken = 1'b1;
    bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    chk("t3_mask", 64'(bus.out_slot_mask_o), 64'b1000);
    chk("t3_taken", 64'(bus.out_taken_o), 64'd0);
    chk("t3_next_pc", bus.out_next_pc_o, 64'h2010);
    drain();

    // Fill, then offer a push alongside a pop while full
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rand_batch();
      tick();
    end
    chk("full_count", 64'(bus.count_o), 64'd4);
    chk("full_in_ready", 64'(bus.in_ready_o), 64'd0);
    rand_batch();
    bus.out_ready_i = 1'b1;
    tick();
    chk("full_pop_count", 64'(bus.count_o), 64'd3);
    drain();

    // Random traffic across pointer wrap
    for (int c = 0; c < 1000; c++) begin
      rand_batch();
      bus.in_valid_i  = 1'($urandom_range(0, 9) < 6);
      bus.out_ready_i = 1'($urandom_range(0, 1));
      bus.flush_i     = 1'($urandom_range(0, 63) == 0);
      tick();
    end
    bus.flush_i = 1'b0;
    drain();

    // Flush wins over same-cycle push and pop
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_batch();
      tick();
    end
    chk("pre_flush_count", 64'(bus.count_o), 64'd3);
    rand_batch();
    bus.out_ready_i = 1'b1;
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.out_ready_i = 1'b0;
    chk("flush_count", 64'(bus.count_o), 64'd0);
    chk("flush_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready_o), 64'd1);

    // Reset mid-stream
    for (int i = 0; i < 2; i++) begin
      rand_batch();
      tick();
    end
    rst = 1'b1;
    bus.flush_i = 1'b1;
    tick();
    rst = 1'b0;
    bus.flush_i = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("rst2_count", 64'(bus.count_o), 64'd0);
    chk("rst2_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst2_in_ready", 64'(bus.in_ready_o), 64'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
